// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time over valid/ready, answered after a fixed
// latency from an internal word array with byte-lane writes and an error flag.
module dmem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned IdxW       = $clog2(DEPTH);
  localparam int unsigned CntW       = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam int unsigned CntInitInt = (LATENCY >= 2) ? LATENCY - 2 : 0;
  localparam logic [CntW-1:0] CntInit = CntW'(CntInitInt);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [31:0]       mem_q [DEPTH];
  logic              accept;
  logic              req_err;
  logic              mem_we;
  logic [IdxW-1:0]   req_idx;

  // ready_q is low throughout reset, so nothing can be accepted until it rises.
  assign accept  = req_valid & ready_q;
  assign req_err = (req_addr[1:0] != 2'b00) | (req_addr[31:2] >= 30'(DEPTH));
  assign req_idx = req_addr[IdxW+1:2];
  assign mem_we  = accept & req_we & ~req_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          err_d   = req_err;
          // Read happens on the acceptance edge, before any later store lands.
          rdata_d = (req_we | req_err) ? 32'h0 : mem_q[req_idx];
          cnt_d   = CntInit;
          state_d = (LATENCY == 1) ? StResp : StWait;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    ready_d = (state_d == StIdle);
    valid_d = (state_d == StResp);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately not reset; a committed store survives a later reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (req_be[i]) begin
          mem_q[req_idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a word-level memory model feeds a queue of expected
// responses that is popped and compared whenever the responder answers.
module tb_dmem_responder;

  localparam int unsigned DEPTH   = 1024;
  localparam int unsigned LATENCY = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int total;
  int bad;

  logic [32:0] exp_q [$];
  logic [31:0] model_mem [int];

  dmem_responder #(
    .DEPTH  (DEPTH),
    .LATENCY(LATENCY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mread(int idx);
    return model_mem.exists(idx) ? model_mem[idx] : 32'h0;
  endfunction

  // Called at a negedge; returns at the negedge of the cycle after acceptance.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input bit push);
    logic        err;
    logic [31:0] word;
    int          n;
    int          idx;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL accept_timeout: req_ready=%b required 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    idx = int'(addr[31:2]);
    err = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'(DEPTH));
    if (err) begin
      if (push) exp_q.push_back({1'b1, 32'h0});
    end else if (we) begin
      word = mread(idx);
      for (int i = 0; i < 4; i++) begin
        if (be[i]) word[8*i +: 8] = wdata[8*i +: 8];
      end
      model_mem[idx] = word;
      if (push) exp_q.push_back({1'b0, 32'h0});
    end else begin
      if (push) exp_q.push_back({1'b0, mread(idx)});
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic collect();
    int          n;
    logic [32:0] exp;
    resp_ready = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (resp_valid !== 1'b1) begin
      bad++;
      $display("FAIL resp_timeout: resp_valid=%b required 1", resp_valid);
      return;
    end
    total++;
    if (n != int'(LATENCY) - 1) begin
      bad++;
      $display("FAIL resp_latency: got %0d cycles after accept cycle, required %0d", n,
               LATENCY - 1);
    end
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty: size=0 required >0");
      return;
    end
    exp = exp_q.pop_front();
    total++;
    if (resp_rdata !== exp[31:0]) begin
      bad++;
      $display("FAIL resp_rdata: got %h required %h", resp_rdata, exp[31:0]);
    end
    total++;
    if (resp_err !== exp[32]) begin
      bad++;
      $display("FAIL resp_err: got %b required %b", resp_err, exp[32]);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    total++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL after_handshake: resp_valid=%b req_ready=%b required 0 1", resp_valid,
               req_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if ({req_ready, resp_valid, resp_err, resp_rdata} !== 35'h0) begin
        bad++;
        $display("FAIL reset_outputs: ready=%b valid=%b err=%b rdata=%h required all 0",
                 req_ready, resp_valid, resp_err, resp_rdata);
      end
    end
    rst = 1'b0;
    #1;
    total++;
    if (req_ready !== 1'b0) begin
      bad++;
      $display("FAIL ready_before_edge: got %b required 0", req_ready);
    end
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_release: got %b required 1", req_ready);
    end
  endtask

  task automatic test_store_load();
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1);
    collect();
    issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
    collect();
  endtask

  task automatic test_byte_enables();
    issue(1'b1, 32'h20, 32'h0, 4'hF, 1'b1);
    collect();
    issue(1'b1, 32'h20, 32'h11223344, 4'h5, 1'b1);
    collect();
    issue(1'b0, 32'h20, 32'h0, 4'h0, 1'b1);
    collect();
    issue(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 1'b1);
    collect();
    issue(1'b0, 32'h20, 32'h0, 4'h0, 1'b1);
    collect();
  endtask

  task automatic test_errors();
    issue(1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, 1'b1);
    collect();
    issue(1'b0, 32'h13, 32'h0, 4'h0, 1'b1);
    collect();
    issue(1'b1, 32'(4 * DEPTH), 32'h5A5A5A5A, 4'hF, 1'b1);
    collect();
    issue(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    collect();
  endtask

  task automatic test_backpressure();
    int          n;
    logic [31:0] first;
    logic [32:0] exp;
    issue(1'b1, 32'h40, 32'h12345678, 4'hF, 1'b1);
    collect();
    issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
    resp_ready = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (resp_valid !== 1'b1) begin
      bad++;
      $display("FAIL bp_resp_timeout: resp_valid=%b required 1", resp_valid);
      return;
    end
    first = resp_rdata;
    // A store held on the request side while busy must never be taken.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h40;
    req_wdata = 32'hFFFFFFFF;
    req_be    = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (resp_valid !== 1'b1 || resp_rdata !== first || req_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold: valid=%b rdata=%h ready=%b required 1 %h 0", resp_valid,
                 resp_rdata, req_ready, first);
      end
    end
    req_valid = 1'b0;
    exp = exp_q.pop_front();
    total++;
    if (resp_rdata !== exp[31:0] || resp_err !== exp[32]) begin
      bad++;
      $display("FAIL bp_data: rdata=%h err=%b required %h %b", resp_rdata, resp_err, exp[31:0],
               exp[32]);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    total++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: valid=%b ready=%b required 0 1", resp_valid, req_ready);
    end
    issue(1'b0, 32'h40, 32'h0, 4'h0, 1'b1);
    collect();
  endtask

  task automatic test_reset_midop();
    issue(1'b1, 32'h30, 32'hCAFEF00D, 4'hF, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 2) rst = 1'b0;
      total++;
      if (resp_valid !== 1'b0) begin
        bad++;
        $display("FAIL midop_no_resp: resp_valid=%b required 0 (cycle %0d)", resp_valid, i);
      end
    end
    issue(1'b0, 32'h30, 32'h0, 4'h0, 1'b1);
    collect();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a;
      a = {24'h0, 2'b01, 4'($urandom_range(0, 15)), 2'b00};
      issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), 1'b1);
      collect();
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    req_be     = 4'h0;
    resp_ready = 1'b0;
    test_reset();
    test_store_load();
    test_byte_enables();
    test_errors();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover: size=%0d required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
